// File: rtl/ex_muldiv_ctrl.sv
// EX-stage HI/LO multiply/divide sequencer; MULDIV_RADIX4_MUL_EN selects 2-bit-per-cycle multiply.
// Latency: HI/LO written 33 cycles after accept (17 for radix-4 multiply); MF*/MT* are combinational/one edge.
// Backpressure: ALUStall holds any HI/LO-class op in EX while the loop is busy; Stall/Flush block acceptance.
module ex_muldiv_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        Valid,
   input  logic        Stall,
   input  logic        Flush,
   input  logic [4:0]  ALUOp,
   input  logic [31:0] ReadData1,
   input  logic [31:0] ReadData2,
   output logic        ALUStall,
   output logic [31:0] MDResult,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);
   localparam logic [4:0] OP_MULT  = 5'd16;
   localparam logic [4:0] OP_MULTU = 5'd17;
   localparam logic [4:0] OP_DIV   = 5'd18;
   localparam logic [4:0] OP_DIVU  = 5'd19;
   localparam logic [4:0] OP_MFHI  = 5'd20;
   localparam logic [4:0] OP_MFLO  = 5'd21;
   localparam logic [4:0] OP_MTHI  = 5'd22;
   localparam logic [4:0] OP_MTLO  = 5'd23;

`ifdef MULDIV_RADIX4_MUL_EN
   localparam logic [4:0] MUL_COUNT = 5'd15;
`else
   localparam logic [4:0] MUL_COUNT = 5'd31;
`endif

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t      state;
   logic [4:0]  count;
   logic        isDiv, negRes, negRem;
   logic [31:0] opnd, accHi, accLo;

   logic        isMdOp, isMulDiv, isMul, opSigned, accept;
   logic [31:0] absA, absB;
   logic [32:0] shifted, diff;
   logic        divNeg;
   logic [63:0] mulNext, prod, prodFix;
   logic [31:0] quoFix, remFix;

   assign isMdOp   = (ALUOp >= OP_MULT) && (ALUOp <= OP_MTLO);
   assign isMulDiv = (ALUOp >= OP_MULT) && (ALUOp <= OP_DIVU);
   assign isMul    = (ALUOp == OP_MULT) || (ALUOp == OP_MULTU);
   assign opSigned = (ALUOp == OP_MULT) || (ALUOp == OP_DIV);

   assign Busy     = (state != IDLE);
   assign ALUStall = Valid & Busy & isMdOp;
   assign accept   = Valid & ~Stall & ~Flush & ~ALUStall;

   assign absA = (opSigned && ReadData1[31]) ? (~ReadData1 + 32'd1) : ReadData1;
   assign absB = (opSigned && ReadData2[31]) ? (~ReadData2 + 32'd1) : ReadData2;

   function automatic logic [63:0] mulStep(input logic [63:0] p, input logic [31:0] m);
      logic [32:0] s;
      s = {1'b0, p[63:32]} + (p[0] ? {1'b0, m} : 33'd0);
      return {s, p[31:1]};
   endfunction

`ifdef MULDIV_RADIX4_MUL_EN
   assign mulNext = mulStep(mulStep({accHi, accLo}, opnd), opnd);
`else
   assign mulNext = mulStep({accHi, accLo}, opnd);
`endif

   // Remainder < divisor, so a set shifted[32] guarantees a non-negative trial difference.
   assign shifted = {accHi, accLo[31]};
   assign diff    = shifted - {1'b0, opnd};
   assign divNeg  = ~shifted[32] & diff[32];

   assign prod    = {accHi, accLo};
   assign prodFix = negRes ? (~prod + 64'd1) : prod;
   assign quoFix  = negRes ? (~accLo + 32'd1) : accLo;
   assign remFix  = negRem ? (~accHi + 32'd1) : accHi;

   always_comb begin
      MDResult = 32'd0;
      if (ALUOp == OP_MFHI)
         MDResult = HI;
      else if (ALUOp == OP_MFLO)
         MDResult = LO;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         count  <= 5'd0;
         isDiv  <= 1'b0;
         negRes <= 1'b0;
         negRem <= 1'b0;
         opnd   <= 32'd0;
         accHi  <= 32'd0;
         accLo  <= 32'd0;
         HI     <= 32'd0;
         LO     <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (accept && isMulDiv) begin
                  isDiv <= ~isMul;
                  accHi <= 32'd0;
                  state <= RUN;
                  if (isMul) begin
                     opnd   <= absA;
                     accLo  <= absB;
                     count  <= MUL_COUNT;
                     negRes <= opSigned & (ReadData1[31] ^ ReadData2[31]);
                     negRem <= 1'b0;
                  end else begin
                     opnd   <= absB;
                     accLo  <= absA;
                     count  <= 5'd31;
                     // Divide by zero keeps the all-ones quotient unsigned.
                     negRes <= opSigned & (ReadData1[31] ^ ReadData2[31]) & (ReadData2 != 32'd0);
                     negRem <= opSigned & ReadData1[31];
                  end
               end
               if (accept && (ALUOp == OP_MTHI))
                  HI <= ReadData1;
               if (accept && (ALUOp == OP_MTLO))
                  LO <= ReadData1;
            end
            RUN: begin
               if (isDiv) begin
                  accHi <= divNeg ? shifted[31:0] : diff[31:0];
                  accLo <= {accLo[30:0], ~divNeg};
               end else begin
                  {accHi, accLo} <= mulNext;
               end
               if (count == 5'd0)
                  state <= FIX;
               else
                  count <= count - 5'd1;
            end
            FIX: begin
               if (isDiv) begin
                  HI <= remFix;
                  LO <= quoFix;
               end else begin
                  HI <= prodFix[63:32];
                  LO <= prodFix[31:0];
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Self-checking bench for ex_muldiv_ctrl: vector table with a scoreboard queue, then stall/flush/reset sequences.
module tb_ex_muldiv_ctrl;
   localparam logic [4:0] OP_MULT  = 5'd16;
   localparam logic [4:0] OP_MULTU = 5'd17;
   localparam logic [4:0] OP_DIV   = 5'd18;
   localparam logic [4:0] OP_DIVU  = 5'd19;
   localparam logic [4:0] OP_MFHI  = 5'd20;
   localparam logic [4:0] OP_MFLO  = 5'd21;
   localparam logic [4:0] OP_MTHI  = 5'd22;
`ifdef MULDIV_RADIX4_MUL_EN
   localparam int MUL_LAT = 17;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;
   localparam int NVEC    = 9;

   logic        clk = 1'b0;
   logic        rst, Valid, Stall, Flush;
   logic [4:0]  ALUOp;
   logic [31:0] ReadData1, ReadData2;
   logic        ALUStall, Busy;
   logic [31:0] MDResult, HI, LO;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } exp_t;

   vec_t vecs [NVEC];
   exp_t sb[$];
   int   nChecks = 0;
   int   nPass = 0;

   ex_muldiv_ctrl dut (
      .clk(clk), .rst(rst), .Valid(Valid), .Stall(Stall), .Flush(Flush),
      .ALUOp(ALUOp), .ReadData1(ReadData1), .ReadData2(ReadData2),
      .ALUStall(ALUStall), .MDResult(MDResult), .Busy(Busy), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act === exp)
         nPass++;
      else
         $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;
      int   stalls;
      int   busyCnt;

      vecs[0] = '{OP_MULT,  32'd7,          32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[1] = '{OP_DIVU,  32'd100,        32'd7,        32'd2,        32'd14};
      vecs[2] = '{OP_DIV,   32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3] = '{OP_DIVU,  32'd5,          32'd0,        32'd5,        32'hFFFFFFFF};
      vecs[4] = '{OP_DIV,   32'h80000000,   32'hFFFFFFFF, 32'd0,        32'h80000000};
      vecs[5] = '{OP_MULTU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[6] = '{OP_MULT,  32'h80000000,   32'h80000000, 32'h40000000, 32'h00000000};
      vecs[7] = '{OP_DIV,   32'd7,          32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
      vecs[8] = '{OP_DIVU,  32'hFFFFFFFF,   32'd16,       32'd15,       32'h0FFFFFFF};

      rst = 1'b1; Valid = 1'b0; Stall = 1'b0; Flush = 1'b0;
      ALUOp = 5'd0; ReadData1 = 32'd0; ReadData2 = 32'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0; Valid = 1'b1; ALUOp = OP_MFHI;
      #1;
      check("reset busy", 32'(Busy), 0);
      check("reset alustall", 32'(ALUStall), 0);
      check("reset hi", HI, 32'd0);
      check("reset lo", LO, 32'd0);
      check("reset mdresult", MDResult, 32'd0);

      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         Valid = 1'b1; ALUOp = vecs[i].op; ReadData1 = vecs[i].a; ReadData2 = vecs[i].b;
         e.hi  = vecs[i].hi;
         e.lo  = vecs[i].lo;
         e.lat = (vecs[i].op == OP_MULT || vecs[i].op == OP_MULTU) ? MUL_LAT : DIV_LAT;
         sb.push_back(e);
         @(negedge clk);
         ALUOp = OP_MFLO; ReadData1 = 32'd0; ReadData2 = 32'd0;
         #1;
         stalls = 0;
         while (ALUStall && stalls < 200) begin
            stalls++;
            @(negedge clk);
            #1;
         end
         if (sb.size() == 0) begin
            check($sformatf("vec%0d scoreboard empty", i), 32'd0, 32'd1);
         end else begin
            e = sb.pop_front();
            check($sformatf("vec%0d stall cycles", i), stalls, e.lat);
            check($sformatf("vec%0d mflo", i), MDResult, e.lo);
            @(negedge clk);
            ALUOp = OP_MFHI;
            #1;
            check($sformatf("vec%0d mfhi", i), MDResult, e.hi);
            check($sformatf("vec%0d hi port", i), HI, e.hi);
            check($sformatf("vec%0d lo port", i), LO, e.lo);
         end
         Valid = 1'b0;
      end

      // MTHI arriving 3 cycles into a multiply waits, then overrides the product HI.
      @(negedge clk);
      Valid = 1'b1; ALUOp = OP_MULT; ReadData1 = 32'd7; ReadData2 = 32'hFFFFFFFD;
      @(negedge clk);
      Valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      Valid = 1'b1; ALUOp = OP_MTHI; ReadData1 = 32'h1234; ReadData2 = 32'd0;
      #1;
      check("mthi stalled", 32'(ALUStall), 1);
      stalls = 0;
      while (ALUStall && stalls < 200) begin
         stalls++;
         @(negedge clk);
         #1;
      end
      check("mthi stall cycles", stalls, MUL_LAT - 2);
      check("mthi product hi first", HI, 32'hFFFFFFFF);
      @(negedge clk);
      Valid = 1'b0;
      #1;
      check("mthi hi", HI, 32'h1234);
      check("mthi lo kept", LO, 32'hFFFFFFEB);

      // Flushed multiply must not start.
      @(negedge clk);
      Valid = 1'b1; Flush = 1'b1; ALUOp = OP_MULT; ReadData1 = 32'd5; ReadData2 = 32'd6;
      @(negedge clk);
      Valid = 1'b0; Flush = 1'b0;
      #1;
      check("flush busy", 32'(Busy), 0);
      check("flush hi", HI, 32'h1234);
      check("flush lo", LO, 32'hFFFFFFEB);

      // Four stalled cycles, then one acceptance: exactly one operation's worth of Busy.
      @(negedge clk);
      Valid = 1'b1; Stall = 1'b1; ALUOp = OP_MULTU; ReadData1 = 32'd3; ReadData2 = 32'd5;
      busyCnt = 0;
      repeat (3) begin
         @(negedge clk);
         #1;
         if (Busy) busyCnt++;
      end
      check("stall no accept", busyCnt, 0);
      @(negedge clk);
      Stall = 1'b0;
      @(negedge clk);
      Valid = 1'b0;
      busyCnt = 0;
      repeat (60) begin
         #1;
         if (Busy) busyCnt++;
         @(negedge clk);
      end
      check("stall single op", busyCnt, MUL_LAT);
      check("stall op lo", LO, 32'd15);
      check("stall op hi", HI, 32'd0);

      // Reset during RUN cycle 10 aborts the loop and clears HI/LO.
      @(negedge clk);
      Valid = 1'b1; ALUOp = OP_MULT; ReadData1 = 32'd7; ReadData2 = 32'hFFFFFFFD;
      @(negedge clk);
      Valid = 1'b0;
      repeat (9) @(negedge clk);
      #1;
      check("pre-reset busy", 32'(Busy), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; Valid = 1'b1; ALUOp = OP_MFLO;
      #1;
      check("abort busy", 32'(Busy), 0);
      check("abort alustall", 32'(ALUStall), 0);
      check("abort hi", HI, 32'd0);
      check("abort lo", LO, 32'd0);
      check("abort mdresult", MDResult, 32'd0);
      Valid = 1'b0;

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end
endmodule
